udma_i2c_cmd_packer: RTL
========================

Name: udma_i2c_cmd_packer

Overview:
Sits directly upstream of the I2C control FSM's 32-bit command channel (udma_cmd_i / udma_cmd_valid_i / udma_cmd_ready_o). Receives the uDMA TX stream in 8-, 16- or 32-bit units and assembles them into 32-bit command words. Buffers the words in a small FIFO and presents them with a valid/ready handshake. Optionally filters out words whose opcode is illegal and flags an error.

Parameters:
- DEPTH, 4, command FIFO depth in 32-bit words. Must be a power of 2 and at least 2.

Ports:
- clk_i, input, 1, master clock.
- rstn_i, input, 1, asynchronous active-low reset.
- sw_rst_i, input, 1, synchronous soft reset/flush, active high.
- cfg_datasize_i, input, 2, fragment size: 00 = byte, 01 = halfword, 10 or 11 = word.
- data_i, input, 32, TX fragment, LSB-aligned.
- data_valid_i, input, 1, fragment valid.
- data_ready_o, output, 1, fragment accepted when valid & ready.
- cmd_o, output, 32, command word to the control FSM.
- cmd_valid_o, output, 1, command word available.
- cmd_ready_i, input, 1, control FSM accepts the word.
- err_o, output, 1, one-cycle pulse when an illegal command is dropped.
- level_o, output, $clog2(DEPTH+1), number of words held in the FIFO.

Behaviour:
- Reset (rstn_i low, async):
  - FIFO empty, assembler cleared.
  - Outputs: cmd_valid_o = 0, cmd_o = 0, err_o = 0, level_o = 0, data_ready_o = 0.
- Soft reset (sw_rst_i high, sampled at the clock edge):
  - Same clearing as async reset; any partial word is discarded.
  - While sw_rst_i is high: data_ready_o is forced to 1 so the uDMA channel drains, and cmd_valid_o is forced to 0.
- Assembler state: r_word[31:0], r_cnt[1:0] (fragments received so far), r_size (datasize latched for the current word).
- Datasize sampling: cfg_datasize_i is sampled only at a word boundary (r_cnt == 0, first fragment). A change mid-word is ignored until the next boundary.
- Packing is little-endian, using only the low bits of data_i:
  - Byte mode: fragment k goes to bits [8k+7:8k]; the word completes on the 4th byte.
  - Halfword mode: fragment k goes to bits [16k+15:16k]; the word completes on the 2nd halfword.
  - Word mode: every fragment is a complete word.
- Push: the completing fragment is written to the FIFO in its acceptance cycle, as {that fragment, r_word bits below it}. r_cnt then returns to 0.
- data_ready_o = ~fifo_full. It is registered-derived, with no combinational path from cmd_ready_i. While full, partial fragments are also stalled.
- FIFO: registered storage, no bypass.
  - A word pushed at cycle N is visible on cmd_valid_o/cmd_o at cycle N+1.
  - Pop occurs on cmd_valid_o & cmd_ready_i.
  - Simultaneous push and pop when not full: level_o unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are distinguished by a separate count.
- cmd_o holds the head word while cmd_valid_o is high and stable until it is popped.
- level_o counts words only; a partial word in the assembler is not included.

Optional Feature:
- Macro UDMA_I2C_CMD_CHECK_EN.
- Defined:
  - A completed word whose opcode, bits [31:28], is not one of the ten legal opcodes is not pushed.
  - err_o pulses 1 for one cycle in the cycle after the drop. data_ready_o is unaffected.
  - The legal opcodes are START, STOP, RD_ACK, RD_NACK, WR, WAIT, WAIT_EV, RPT, CFG, WRB.
- Undefined: every completed word is pushed, and err_o is tied to 0.

Decomposition:
- Package udma_i2c_pkg holds:
  - the 4-bit opcode constants (shared with the control FSM),
  - the datasize typedef (BYTE, HALF, WORD),
  - the is_legal_opcode function used under the macro.
- One sub-module: udma_i2c_cmd_fifo, a generic synchronous FIFO with parameters WIDTH = 32 and DEPTH, a clear input, and full, empty and count outputs.
- The assembler stays in the top module.

Test Plan:
- Byte mode, fragments 0x11, 0x22, 0x33, 0x04 with cmd_ready_i = 1 → one word 0x04332211 on cmd_o, cmd_valid_o high exactly 1 cycle after the 4th fragment is accepted.
- Halfword mode, fragments 0xBEEF then 0x1000 (upper data_i bits garbage) → cmd_o = 0x1000BEEF; upper input bits ignored.
- Word mode, DEPTH = 4, cmd_ready_i = 0, 5 words sent → level_o reaches 4 and data_ready_o = 0. Release ready → words pop in order, data_ready_o returns to 1 the cycle after the first pop, and the 5th word arrives last.
- Byte mode, 2 bytes accepted, then sw_rst_i for 1 cycle, then 4 new bytes → only the new word appears; level_o = 0 during reset; data_ready_o = 1 during reset.
- cfg_datasize_i switched from byte to word after the 1st byte → the current word still completes after 4 bytes; the next word is taken whole.
- UDMA_I2C_CMD_CHECK_EN defined, word with an illegal opcode, then a legal CFG word → only the CFG word emitted and err_o pulses once. Macro undefined → both words emitted and err_o stays 0.

Source files
------------

// File: rtl/udma_i2c_pkg.sv
// Shared definitions for the uDMA I2C command path: opcodes, fragment sizes,
// and the opcode legality check used when UDMA_I2C_CMD_CHECK_EN is defined.
package udma_i2c_pkg;

  localparam logic [3:0] I2C_CMD_START   = 4'h0;
  localparam logic [3:0] I2C_CMD_WAIT_EV = 4'h1;
  localparam logic [3:0] I2C_CMD_STOP    = 4'h2;
  localparam logic [3:0] I2C_CMD_RD_ACK  = 4'h4;
  localparam logic [3:0] I2C_CMD_RD_NACK = 4'h6;
  localparam logic [3:0] I2C_CMD_WRB     = 4'h7;
  localparam logic [3:0] I2C_CMD_WR      = 4'h8;
  localparam logic [3:0] I2C_CMD_WAIT    = 4'hA;
  localparam logic [3:0] I2C_CMD_RPT     = 4'hC;
  localparam logic [3:0] I2C_CMD_CFG     = 4'hE;

  typedef enum logic [1:0] {
    DS_BYTE = 2'b00,
    DS_HALF = 2'b01,
    DS_WORD = 2'b10
  } datasize_e;

  // Both 2'b10 and 2'b11 select whole-word fragments.
  function automatic datasize_e decode_datasize(input logic [1:0] cfg);
    return cfg[1] ? DS_WORD : datasize_e'(cfg);
  endfunction

  function automatic logic is_legal_opcode(input logic [3:0] op);
    case (op)
      I2C_CMD_START, I2C_CMD_WAIT_EV, I2C_CMD_STOP, I2C_CMD_RD_ACK,
      I2C_CMD_RD_NACK, I2C_CMD_WRB, I2C_CMD_WR, I2C_CMD_WAIT,
      I2C_CMD_RPT, I2C_CMD_CFG: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/udma_i2c_cmd_fifo.sv
// Generic synchronous FIFO with registered storage, no bypass, and a
// synchronous clear. Full/empty come from a separate occupancy count.
module udma_i2c_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           clr_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: storage carries no reset; an empty FIFO's head is masked by the
  // consumer, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/udma_i2c_cmd_packer.sv
// Packs 8/16/32-bit uDMA TX fragments little-endian into 32-bit I2C command
// words and queues them. Define UDMA_I2C_CMD_CHECK_EN to drop illegal opcodes.
module udma_i2c_cmd_packer
  import udma_i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           sw_rst_i,
  input  logic [1:0]                     cfg_datasize_i,
  input  logic [31:0]                    data_i,
  input  logic                           data_valid_i,
  output logic                           data_ready_o,
  output logic [31:0]                    cmd_o,
  output logic                           cmd_valid_o,
  input  logic                           cmd_ready_i,
  output logic                           err_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  logic [31:0] word_q, word_d, push_word, head_word;
  logic [1:0]  cnt_q, cnt_d;
  datasize_e   size_q, size_d, size_cur;
  logic        rdy_en_q;
  logic        accept, last, legal, push, pop;
  logic        fifo_full, fifo_empty;

  // rdy_en_q holds data_ready_o low while rstn_i is asserted.
  assign data_ready_o = rdy_en_q & (sw_rst_i | ~fifo_full);
  assign accept       = data_valid_i & data_ready_o & ~sw_rst_i;
  assign size_cur     = (cnt_q == 2'd0) ? decode_datasize(cfg_datasize_i) : size_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    push_word = word_q;
    last      = 1'b0;
    case (size_cur)
      DS_BYTE: begin
        push_word[{cnt_q, 3'b000} +: 8] = data_i[7:0];
        last = (cnt_q == 2'd3);
      end
      DS_HALF: begin
        push_word[{cnt_q[0], 4'b0000} +: 16] = data_i[15:0];
        last = cnt_q[0];
      end
      default: begin
        push_word = data_i;
        last      = 1'b1;
      end
    endcase
  end

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    size_d = size_q;
    if (sw_rst_i) begin
      word_d = '0;
      cnt_d  = '0;
      size_d = DS_BYTE;
    end else if (accept) begin
      word_d = push_word;
      size_d = size_cur;
      cnt_d  = last ? 2'd0 : cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_q   <= '0;
      cnt_q    <= '0;
      size_q   <= DS_BYTE;
      rdy_en_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef UDMA_I2C_CMD_CHECK_EN
  logic err_q;

  assign legal = is_legal_opcode(push_word[31:28]);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       err_q <= 1'b0;
    else if (sw_rst_i) err_q <= 1'b0;
    else               err_q <= accept & last & ~legal;
  end

  assign err_o = err_q;
`else
  assign legal = 1'b1;
  assign err_o = 1'b0;
`endif

  assign push        = accept & last & legal;
  assign cmd_valid_o = ~fifo_empty & ~sw_rst_i;
  assign pop         = cmd_valid_o & cmd_ready_i;
  assign cmd_o       = fifo_empty ? '0 : head_word;

  udma_i2c_cmd_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (sw_rst_i),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (level_o)
  );

endmodule
